// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into WIDTH-bit words and writes them out.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing modulo-256 checksum byte after the last word.
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [6:0]       num_words,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             we,
  output logic [5:0]       waddr,
  output logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE, S_CHECK} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_e;
`endif

  localparam logic [6:0] DEPTH_C = 7'(DEPTH);

  state_e           state_q, state_d;
  logic [6:0]       nwords_q, nwords_d;
  logic [6:0]       idx_q, idx_d;
  logic [1:0]       bcnt_q, bcnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       sum_q, sum_d;
`endif

  // NOTE: every _d gets its current value first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    nwords_d = nwords_q;
    idx_d    = idx_q;
    bcnt_d   = bcnt_q;
    word_d   = word_q;
    done_d   = done_q;
    error_d  = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d    = sum_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          nwords_d = num_words;
          idx_d    = '0;
          bcnt_d   = '0;
          word_d   = '0;
          done_d   = 1'b0;
          error_d  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d    = '0;
`endif
          // Empty or oversized sessions finish immediately without touching memory.
          if (num_words == 7'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (num_words > DEPTH_C) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            error_d = 1'b1;
          end else begin
            state_d = S_RECV;
          end
        end
      end

      S_RECV: begin
        if (byte_valid) begin
          word_d[{bcnt_q, 3'b000} +: 8] = byte_data;
          bcnt_d = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d  = sum_q + byte_data;
`endif
          if (bcnt_q == 2'd3) state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        idx_d = idx_q + 7'd1;
        if (idx_d == nwords_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
          done_d  = 1'b1;
          error_d = 1'b0;
`endif
        end else begin
          state_d = S_RECV;
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (byte_valid) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          error_d = (byte_data != sum_q);
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous and wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      nwords_q <= '0;
      idx_q    <= '0;
      bcnt_q   <= '0;
      word_q   <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      nwords_q <= nwords_d;
      idx_q    <= idx_d;
      bcnt_q   <= bcnt_d;
      word_q   <= word_d;
      done_q   <= done_d;
      error_q  <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign byte_ready = (state_q == S_RECV) || (state_q == S_CHECK);
  assign busy       = (state_q == S_RECV) || (state_q == S_WRITE) || (state_q == S_CHECK);
`else
  assign byte_ready = (state_q == S_RECV);
  assign busy       = (state_q == S_RECV) || (state_q == S_WRITE);
`endif

  // The index bound is redundant with the start-time range check but keeps the strobe safe by construction.
  assign we    = (state_q == S_WRITE) && (idx_q < DEPTH_C);
  assign waddr = idx_q[5:0];
  assign wdata = word_q;
  assign done  = done_q;
  assign error = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a byte-list reference model.
// Define IMEM_LOADER_CHECKSUM_EN to exercise the checksum variant.
module tb_imem_loader;
  localparam int DEPTH = 64;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [6:0]       num_words;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic             we;
  logic [5:0]       waddr;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             error;

  imem_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Write log captured mid-cycle; strobes overlapping byte_ready or out of range are flagged.
  logic [5:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          bad_strobe = 0;

  always @(negedge clk) begin
    if (we === 1'b1) begin
      wr_addr.push_back(waddr);
      wr_data.push_back(wdata);
      if (byte_ready !== 1'b0 || int'(waddr) >= DEPTH) bad_strobe++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_word(input logic [7:0] b[$], input int i);
    return {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
  endfunction

  function automatic logic [7:0] model_sum(input logic [7:0] b[$]);
    int s = 0;
    foreach (b[i]) s += int'(b[i]);
    return 8'(s % 256);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic start_session(input int n);
    start     = 1'b1;
    num_words = 7'(n);
    tick();
    start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    int   t;
    byte_valid = 1'b0;
    repeat (gap) tick();
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    do begin
      acc = byte_ready;
      tick();
      t++;
    end while (!acc && t < 40);
    byte_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_byte_timeout: byte_ready=%b, required 1 within 40 cycles", byte_ready);
    end
  endtask

  task automatic wait_done(input int limit, output int waited);
    waited = 0;
    while (done !== 1'b1 && waited < limit) begin
      tick();
      waited++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_timeout: done=%b, required 1 within %0d cycles", done, limit);
    end
  endtask

  // Full session: start, stream bytes with random gaps, optional checksum, wait for done.
  task automatic load(input logic [7:0] b[$], input int n, input int gap, output int cycles);
    int w;
    start_session(n);
    cycles = 0;
    foreach (b[i]) begin
      int g = (gap == 0) ? 0 : int'($urandom_range(0, gap));
      int t0 = int'($time);
      send_byte(b[i], g);
      cycles += (int'($time) - t0) / 10;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    begin
      int t0 = int'($time);
      send_byte(model_sum(b), 0);
      cycles += (int'($time) - t0) / 10;
    end
`endif
    wait_done(200, w);
    cycles += w;
  endtask

  task automatic verify_writes(input string name, input logic [7:0] b[$], input int n);
    n_checks++;
    if (wr_addr.size() !== n) begin
      n_fail++;
      $display("FAIL %s_write_count: got %0d, required %0d", name, wr_addr.size(), n);
    end
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      n_checks++;
      if (wr_addr[i] !== 6'(i) || wr_data[i] !== model_word(b, i)) begin
        n_fail++;
        $display("FAIL %s_word%0d: got addr=%0d data=%08h, required addr=%0d data=%08h",
                 name, i, wr_addr[i], wr_data[i], i, model_word(b, i));
      end
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1; start = 1'b0; num_words = '0; byte_valid = 1'b0; byte_data = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({byte_ready, we, waddr, wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_datapath: got ready=%b we=%b waddr=%0d wdata=%08h, required all 0",
               byte_ready, we, waddr, wdata);
    end
    n_checks++;
    if ({busy, done, error} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_status: got busy/done/error=%b, required 000", {busy, done, error});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b[$] = '{8'h0F, 8'h00, 8'h4F, 8'hE0, 8'h02, 8'h00, 8'h80, 8'hE2};
    int cyc;
    int exp_cyc;
    clear_log();
    load(b, 2, 0, cyc);
    verify_writes("b2b", b, 2);
    n_checks++;
    if (wr_data.size() != 2 || wr_data[0] !== 32'hE04F000F || wr_data[1] !== 32'hE2800002) begin
      n_fail++;
      $display("FAIL b2b_const: got %0d words, required E04F000F,E2800002", wr_data.size());
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_cyc = 5 * 2 + 1;
`else
    exp_cyc = 5 * 2;
`endif
    n_checks++;
    if (cyc !== exp_cyc) begin
      n_fail++;
      $display("FAIL b2b_throughput: got %0d cycles, required %0d", cyc, exp_cyc);
    end
    repeat (5) tick();
    n_checks++;
    if ({busy, done, error} !== 3'b010) begin
      n_fail++;
      $display("FAIL b2b_done_hold: got busy/done/error=%b, required 010", {busy, done, error});
    end
  endtask

  task automatic test_zero_words();
    clear_log();
    start_session(0);
    n_checks++;
    if ({busy, done, error} !== 3'b010) begin
      n_fail++;
      $display("FAIL zero_status: got busy/done/error=%b, required 010", {busy, done, error});
    end
    repeat (4) tick();
    n_checks++;
    if (wr_addr.size() !== 0) begin
      n_fail++;
      $display("FAIL zero_no_write: got %0d writes, required 0", wr_addr.size());
    end
  endtask

  task automatic test_overflow();
    clear_log();
    start_session(DEPTH + 1);
    n_checks++;
    if ({busy, done, error} !== 3'b011) begin
      n_fail++;
      $display("FAIL overflow_status: got busy/done/error=%b, required 011", {busy, done, error});
    end
    repeat (4) tick();
    n_checks++;
    if (wr_addr.size() !== 0) begin
      n_fail++;
      $display("FAIL overflow_no_write: got %0d writes, required 0", wr_addr.size());
    end
  endtask

  task automatic test_gapped();
    logic [7:0]  b[$];
    logic [31:0] ref_data[$];
    int cyc;
    for (int i = 0; i < 12; i++) b.push_back(8'($urandom));
    clear_log();
    load(b, 3, 0, cyc);
    ref_data = wr_data;
    clear_log();
    load(b, 3, 3, cyc);
    verify_writes("gapped", b, 3);
    n_checks++;
    if (wr_data != ref_data) begin
      n_fail++;
      $display("FAIL gapped_vs_gapfree: got %0d words, required identical to gap-free %0d words",
               wr_data.size(), ref_data.size());
    end
    n_checks++;
    if (error !== 1'b0) begin
      n_fail++;
      $display("FAIL gapped_error: got %b, required 0", error);
    end
  endtask

  task automatic test_start_ignored();
    logic [7:0] b[$];
    int w;
    for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
    clear_log();
    start_session(1);
    send_byte(b[0], 0);
    send_byte(b[1], 0);
    start = 1'b1;
    num_words = 7'd0;
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_start_state: got busy=%b done=%b, required busy=1 done=0", busy, done);
    end
    send_byte(b[2], 1);
    send_byte(b[3], 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(model_sum(b), 0);
`endif
    wait_done(50, w);
    verify_writes("ignored_start", b, 1);
  endtask

  task automatic test_reset_mid();
    logic [7:0] b[$];
    logic [7:0] b2[$];
    int cyc;
    for (int i = 0; i < 8; i++) b.push_back(8'($urandom));
    clear_log();
    start_session(2);
    for (int i = 0; i < 6; i++) send_byte(b[i], 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({byte_ready, we, waddr, wdata, busy, done, error} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got ready=%b we=%b waddr=%0d wdata=%08h busy=%b done=%b error=%b, required all 0",
               byte_ready, we, waddr, wdata, busy, done, error);
    end
    repeat (6) tick();
    verify_writes("midreset", b, 1);
    for (int i = 0; i < 8; i++) b2.push_back(8'($urandom));
    clear_log();
    load(b2, 2, 2, cyc);
    verify_writes("after_reset", b2, 2);
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] b[$] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] sums[2] = '{8'h0A, 8'h0B};
    int w;
    for (int k = 0; k < 2; k++) begin
      clear_log();
      start_session(1);
      foreach (b[i]) send_byte(b[i], 0);
      send_byte(sums[k], 0);
      wait_done(50, w);
      verify_writes("checksum", b, 1);
      n_checks++;
      if (error !== 1'(k)) begin
        n_fail++;
        $display("FAIL checksum_%02h_error: got %b, required %0d", sums[k], error, k);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_zero_words();
    test_overflow();
    test_gapped();
    test_start_ignored();
    test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    n_checks++;
    if (bad_strobe !== 0) begin
      n_fail++;
      $display("FAIL write_strobe_rules: got %0d bad strobes, required 0", bad_strobe);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
